// File: rtl/pc_unit.sv
// Registered program counter with stall, exception entry/return and
// jr alignment-fault detection.
module pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic [2:0]       i_npc_sel,
  input  logic             i_cond,
  input  logic [25:0]      i_imm,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_exc_req,
  input  logic             i_eret,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pcp4,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_exl,
  output logic             o_fault
);

  localparam logic [WIDTH-1:0] ResetVec = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] ExcVec   = WIDTH'(EXC_VEC);

  localparam logic [2:0] SelSeq    = 3'b000;
  localparam logic [2:0] SelBranch = 3'b001;
  localparam logic [2:0] SelJump   = 3'b010;
  localparam logic [2:0] SelJr     = 3'b100;

  logic [WIDTH-1:0] r_pc, r_epc;
  logic             r_exl, r_fault;
  logic [WIDTH-1:0] w_pc_d, w_epc_d;
  logic             w_exl_d, w_fault_d;

  logic [WIDTH-1:0] w_pcp4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_nxt;
  logic             w_jr_mis;

  assign w_pcp4   = r_pc + WIDTH'(4);
  // Sign-extended word offset from the low 16 immediate bits.
  assign w_br_off = {{(WIDTH-18){i_imm[15]}}, i_imm[15:0], 2'b00};
  assign w_jr_mis = (i_npc_sel == SelJr) && (i_target[1:0] != 2'b00);

  // Candidate next PC from the selected mode; unknown codes fall back to sequential.
  always_comb begin
    w_nxt = w_pcp4;
    case (i_npc_sel)
      SelSeq:    w_nxt = w_pcp4;
      SelBranch: w_nxt = i_cond ? (w_pcp4 + w_br_off) : w_pcp4;
      SelJump:   w_nxt = {w_pcp4[WIDTH-1:28], i_imm, 2'b00};
      SelJr:     w_nxt = i_target;
      default:   w_nxt = w_pcp4;
    endcase
  end

  // Prioritised next-state: exception, jr fault, eret, advance, hold.
  always_comb begin
    w_pc_d    = r_pc;
    w_epc_d   = r_epc;
    w_exl_d   = r_exl;
    w_fault_d = 1'b0;
    if (i_exc_req && !r_exl) begin
      // Taken even under stall; a masked request is not remembered.
      w_epc_d = r_pc;
      w_exl_d = 1'b1;
      w_pc_d  = ExcVec;
    end else if (w_jr_mis && !i_stall) begin
      w_pc_d    = ExcVec;
      w_fault_d = 1'b1;
      if (!r_exl) begin
        w_epc_d = r_pc;
        w_exl_d = 1'b1;
      end
    end else if (i_eret && r_exl && !i_stall) begin
      w_pc_d  = r_epc;
      w_exl_d = 1'b0;
    end else if (!i_stall) begin
      w_pc_d = w_nxt;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= ResetVec;
      r_epc   <= '0;
      r_exl   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_pc    <= w_pc_d;
      r_epc   <= w_epc_d;
      r_exl   <= w_exl_d;
      r_fault <= w_fault_d;
    end
  end

  assign o_pc    = r_pc;
  assign o_pcp4  = w_pcp4;
  assign o_epc   = r_epc;
  assign o_exl   = r_exl;
  assign o_fault = r_fault;

endmodule
